// File: rtl/serial_twos_comp_mc.sv
// Multi-lane bit-serial two's-complement unit (LSB first): captures a framed word per lane
// and re-emits it as a contiguous burst with pass, negate or absolute value applied.
module serial_twos_comp_mc #(
   parameter int CH     = 2,
   parameter int WORD_W = 8
) (
   input  logic          t_clk,
   input  logic          r_n,
   input  logic          in_valid,
   input  logic          sof,
   input  logic [CH-1:0] i,
   input  logic [1:0]    mode,
   output logic          out_valid,
   output logic          out_sof,
   output logic          out_eow,
   output logic [CH-1:0] y,
   output logic [CH-1:0] ovf,
   output logic          frame_err
);

   localparam int            CW   = $clog2(WORD_W);
   localparam logic [CW-1:0] LAST = CW'(WORD_W - 1);

   localparam logic [0:0] CAP_IDLE  = 1'b0;
   localparam logic [0:0] CAP_CAPT  = 1'b1;
   localparam logic [0:0] OUT_IDLE  = 1'b0;
   localparam logic [0:0] OUT_SHIFT = 1'b1;

   logic [0:0]    cap_state_reg;
   logic [CW-1:0] cap_cnt_reg;
   logic [1:0]    cap_mode_reg;
   logic [0:0]    out_state_reg;
   logic [CW-1:0] out_cnt_reg;
   logic [1:0]    out_mode_reg;
   logic          frame_err_reg;

   logic beat_sof;
   logic beat_data;
   logic xfer;
   logic err_next;
   logic shifting;

   assign beat_sof  = in_valid & sof;
   assign beat_data = in_valid & ~sof;
   // The MSB beat hands the whole word to the output side in the same edge.
   assign xfer      = beat_data & (cap_state_reg == CAP_CAPT) & (cap_cnt_reg == LAST);
   assign err_next  = (beat_data & (cap_state_reg == CAP_IDLE)) |
                      (beat_sof & (cap_state_reg == CAP_CAPT));
   assign shifting  = (out_state_reg == OUT_SHIFT);

   always_ff @(posedge t_clk or negedge r_n) begin
      if (!r_n) begin
         cap_state_reg <= CAP_IDLE;
         cap_cnt_reg   <= '0;
         cap_mode_reg  <= 2'b00;
         frame_err_reg <= 1'b0;
      end else begin
         frame_err_reg <= err_next;
         if (beat_sof) begin
            cap_state_reg <= CAP_CAPT;
            cap_cnt_reg   <= CW'(1);
            cap_mode_reg  <= mode;
         end else if (beat_data && cap_state_reg == CAP_CAPT) begin
            if (cap_cnt_reg == LAST) begin
               cap_state_reg <= CAP_IDLE;
               cap_cnt_reg   <= '0;
            end else begin
               cap_cnt_reg <= cap_cnt_reg + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge t_clk or negedge r_n) begin
      if (!r_n) begin
         out_state_reg <= OUT_IDLE;
         out_cnt_reg   <= '0;
         out_mode_reg  <= 2'b00;
      end else if (xfer) begin
         // A transfer on the final emitted bit restarts the burst with no gap.
         out_state_reg <= OUT_SHIFT;
         out_cnt_reg   <= '0;
         out_mode_reg  <= cap_mode_reg;
      end else if (shifting) begin
         if (out_cnt_reg == LAST) begin
            out_state_reg <= OUT_IDLE;
            out_cnt_reg   <= '0;
         end else begin
            out_cnt_reg <= out_cnt_reg + CW'(1);
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < CH; gi++) begin : g_lane
         logic [WORD_W-2:0] cap_word_reg;
         logic [WORD_W-1:0] out_word_reg;
         logic              inv_reg;
         logic              bit_cur;
         logic              neg;
         logic              is_min;

         assign bit_cur = out_word_reg[out_cnt_reg];
         assign neg     = (out_mode_reg == 2'b01) |
                          ((out_mode_reg == 2'b10) & out_word_reg[WORD_W-1]);
         assign is_min  = (out_word_reg == {1'b1, {(WORD_W-1){1'b0}}});

         always_ff @(posedge t_clk or negedge r_n) begin
            if (!r_n) begin
               cap_word_reg <= '0;
               out_word_reg <= '0;
               inv_reg      <= 1'b0;
            end else begin
               if (beat_sof) begin
                  cap_word_reg[0] <= i[gi];
               end else if (beat_data && cap_state_reg == CAP_CAPT && cap_cnt_reg != LAST) begin
                  cap_word_reg[cap_cnt_reg] <= i[gi];
               end
               if (xfer) begin
                  out_word_reg <= {i[gi], cap_word_reg};
                  inv_reg      <= 1'b0;
               end else if (shifting) begin
                  inv_reg <= inv_reg | bit_cur;
               end
            end
         end

         // Bits up to and including the first 1 pass; later bits invert when negating.
         assign y[gi]   = shifting & (bit_cur ^ (neg & inv_reg));
         assign ovf[gi] = shifting & (out_cnt_reg == LAST) & neg & is_min;
      end
   endgenerate

   assign out_valid = shifting;
   assign out_sof   = shifting & (out_cnt_reg == '0);
   assign out_eow   = shifting & (out_cnt_reg == LAST);
   assign frame_err = frame_err_reg;

endmodule
